// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand bypass, load-use / RAW stall, flush bubbles; bypass only with ID_EX_FORWARD_EN.
// Latency one cycle; stall_id (combinational) holds upstream while a bubble enters EX, flush overrides stall.
module id_ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [15:0] id_ctrl,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [31:0] id_rdata1,
    input  logic [31:0] id_rdata2,
    input  logic        id_reg_wr,
    input  logic        id_mem_rd,
    input  logic [31:0] ex_alu_result,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_wr,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_wr,
    input  logic [31:0] wb_wdata,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_imm,
    output logic [15:0] ex_ctrl,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_wr,
    output logic        ex_mem_rd,
    output logic        stall_id
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
    } ex_t;

    ex_t         ex_q, ex_d;
    logic [31:0] op1, op2;
    logic        hazard;

    // A used, nonzero source that a pending producer will still overwrite.
    function automatic logic reads(input logic use_src, input logic [4:0] src,
                                   input logic wr, input logic [4:0] dst);
        return use_src && wr && (dst != 5'd0) && (dst == src);
    endfunction

`ifdef ID_EX_FORWARD_EN
    function automatic logic [31:0] bypass(
        input logic [4:0] src, input logic [31:0] rf,
        input logic e_wr, input logic [4:0] e_dst, input logic [31:0] e_val,
        input logic m_wr, input logic [4:0] m_dst, input logic [31:0] m_val,
        input logic w_wr, input logic [4:0] w_dst, input logic [31:0] w_val);
        if (src == 5'd0)                return rf;
        if (e_wr && (e_dst == src))     return e_val;
        if (m_wr && (m_dst == src))     return m_val;
        if (w_wr && (w_dst == src))     return w_val;
        return rf;
    endfunction
`else
    logic unused_data;
    assign unused_data = ^{ex_alu_result, mem_result, wb_wdata};
`endif

    always_comb begin
        op1    = id_rdata1;
        op2    = id_rdata2;
        hazard = 1'b0;
`ifdef ID_EX_FORWARD_EN
        op1 = bypass(id_rs1, id_rdata1, ex_q.valid && ex_q.reg_wr, ex_q.rd, ex_alu_result,
                     mem_reg_wr, mem_rd, mem_result, wb_reg_wr, wb_rd, wb_wdata);
        op2 = bypass(id_rs2, id_rdata2, ex_q.valid && ex_q.reg_wr, ex_q.rd, ex_alu_result,
                     mem_reg_wr, mem_rd, mem_result, wb_reg_wr, wb_rd, wb_wdata);
        // Only a load in EX cannot be bypassed in time.
        hazard = reads(id_use_rs1, id_rs1, ex_q.valid && ex_q.mem_rd, ex_q.rd) ||
                 reads(id_use_rs2, id_rs2, ex_q.valid && ex_q.mem_rd, ex_q.rd);
`else
        hazard = reads(id_use_rs1, id_rs1, ex_q.valid && ex_q.reg_wr, ex_q.rd) ||
                 reads(id_use_rs2, id_rs2, ex_q.valid && ex_q.reg_wr, ex_q.rd) ||
                 reads(id_use_rs1, id_rs1, mem_reg_wr, mem_rd) ||
                 reads(id_use_rs2, id_rs2, mem_reg_wr, mem_rd) ||
                 reads(id_use_rs1, id_rs1, wb_reg_wr, wb_rd) ||
                 reads(id_use_rs2, id_rs2, wb_reg_wr, wb_rd);
`endif
    end

    assign stall_id = id_valid && !flush && !reset && hazard;

    always_comb begin
        ex_d = ex_q;
        if (id_valid && !flush && !stall_id) begin
            ex_d.valid  = 1'b1;
            ex_d.pc     = id_pc;
            ex_d.op1    = op1;
            ex_d.op2    = op2;
            ex_d.imm    = id_imm;
            ex_d.ctrl   = id_ctrl;
            ex_d.rd     = id_rd;
            ex_d.reg_wr = id_reg_wr;
            ex_d.mem_rd = id_mem_rd;
        end else begin
            // Bubble: payload fields keep their last value.
            ex_d.valid  = 1'b0;
            ex_d.reg_wr = 1'b0;
            ex_d.mem_rd = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_pc     = ex_q.pc;
    assign ex_op1    = ex_q.op1;
    assign ex_op2    = ex_q.op2;
    assign ex_imm    = ex_q.imm;
    assign ex_ctrl   = ex_q.ctrl;
    assign ex_rd     = ex_q.rd;
    assign ex_reg_wr = ex_q.reg_wr;
    assign ex_mem_rd = ex_q.mem_rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios then random stimulus against a reference model.
module tb_id_ex_stage;
    logic        clock = 1'b0;
    logic        reset, id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_mem_rd;
    logic [31:0] id_pc, id_imm, id_rdata1, id_rdata2, ex_alu_result, mem_result, wb_wdata;
    logic [15:0] id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic        mem_reg_wr, wb_reg_wr, flush;
    logic        ex_valid, ex_reg_wr, ex_mem_rd, stall_id;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [15:0] ex_ctrl;
    logic [4:0]  ex_rd;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rdata1(id_rdata1),
        .id_rdata2(id_rdata2), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
        .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .wb_wdata(wb_wdata),
        .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_mem_rd(ex_mem_rd), .stall_id(stall_id)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
    } slot_t;

    slot_t m = '0;
    int    tests = 0;
    int    fails = 0;
    logic  pipe_mode = 1'b0;

    task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registers the decode slot may not read yet, gathered from the pipeline beyond it.
    function automatic logic exp_stall();
        logic [4:0] srcs[$];
        logic [4:0] busy[$];
        if (!id_valid || flush || reset) return 1'b0;
        if (id_use_rs1) srcs.push_back(id_rs1);
        if (id_use_rs2) srcs.push_back(id_rs2);
`ifdef ID_EX_FORWARD_EN
        if (m.valid && m.mem_rd) busy.push_back(m.rd);
`else
        if (m.valid && m.reg_wr) busy.push_back(m.rd);
        if (mem_reg_wr) busy.push_back(mem_rd);
        if (wb_reg_wr) busy.push_back(wb_rd);
`endif
        for (int i = 0; i < srcs.size(); i++)
            for (int j = 0; j < busy.size(); j++)
                if (srcs[i] != 5'd0 && srcs[i] == busy[j]) return 1'b1;
        return 1'b0;
    endfunction

    // Youngest producer of the register wins; x0 always reads the register file.
    function automatic logic [31:0] exp_operand(input logic [4:0] src, input logic [31:0] rf);
        logic [4:0]  dst[3];
        logic        wr[3];
        logic [31:0] val[3];
        dst = '{m.rd, mem_rd, wb_rd};
        val = '{ex_alu_result, mem_result, wb_wdata};
`ifdef ID_EX_FORWARD_EN
        wr = '{m.valid && m.reg_wr, mem_reg_wr, wb_reg_wr};
`else
        wr = '{1'b0, 1'b0, 1'b0};
`endif
        if (src == 5'd0) return rf;
        for (int k = 0; k < 3; k++)
            if (wr[k] && dst[k] == src) return val[k];
        return rf;
    endfunction

    task automatic cycle(input string tag, output logic stall_seen);
        slot_t nxt, old;
        logic  es;
        @(negedge clock);
        es = exp_stall();
        stall_seen = stall_id;
        chk({tag, ".stall"}, {151'b0, stall_id}, {151'b0, es});
        nxt = m;
        if (reset) begin
            nxt = '0;
        end else if (id_valid && !flush && !es) begin
            nxt.valid  = 1'b1;
            nxt.pc     = id_pc;
            nxt.op1    = exp_operand(id_rs1, id_rdata1);
            nxt.op2    = exp_operand(id_rs2, id_rdata2);
            nxt.imm    = id_imm;
            nxt.ctrl   = id_ctrl;
            nxt.rd     = id_rd;
            nxt.reg_wr = id_reg_wr;
            nxt.mem_rd = id_mem_rd;
        end else begin
            nxt.valid  = 1'b0;
            nxt.reg_wr = 1'b0;
            nxt.mem_rd = 1'b0;
        end
        @(posedge clock);
        #1;
        old = m;
        m = nxt;
        chk({tag, ".ex"}, {ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_ctrl, ex_rd,
                           ex_reg_wr, ex_mem_rd}, m);
        if (pipe_mode) begin
            wb_rd      = mem_rd;
            wb_reg_wr  = mem_reg_wr;
            wb_wdata   = mem_result;
            mem_rd     = old.rd;
            mem_reg_wr = old.reg_wr;
            mem_result = ex_alu_result;
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic wr, input logic ld, input logic [31:0] d1,
                          input logic [31:0] d2);
        id_valid = v;  id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd;    id_reg_wr = wr; id_mem_rd = ld; id_rdata1 = d1; id_rdata2 = d2;
        id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
    endtask

    task automatic drain();
        logic s;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) cycle("drain", s);
    endtask

    initial begin
        logic        s;
        int          n;
        int          exp_n;
        logic [31:0] exp_v;

        reset = 1'b1; flush = 1'b0; ex_alu_result = '0;
        mem_rd = '0; mem_reg_wr = 1'b0; mem_result = '0;
        wb_rd = '0;  wb_reg_wr = 1'b0;  wb_wdata = '0;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 32'h5, 32'h6);
        cycle("rst0", s);
        cycle("rst1", s);
        chk("rst.outs", {ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_ctrl, ex_rd,
                         ex_reg_wr, ex_mem_rd}, 152'd0);
        chk("rst.stall_id", {151'b0, stall_id}, 152'd0);

        reset = 1'b0; pipe_mode = 1'b1;
        drain();

        // ALU producer x4 followed by a consumer of x4
        ex_alu_result = 32'h40;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle("add4", s);
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h44, 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("use4", s);
            if (!s) break;
            n++;
        end
`ifdef ID_EX_FORWARD_EN
        exp_n = 0; exp_v = 32'h40;
`else
        exp_n = 3; exp_v = 32'h44;
`endif
        chk("use4.stall_cycles", 152'(n), 152'(exp_n));
        chk("use4.op1", {120'b0, ex_op1}, {120'b0, exp_v});
        drain();

        // Load x3 followed by a consumer of x3
        ex_alu_result = 32'h33;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'd0, 32'd0);
        cycle("lw3", s);
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 32'h99, 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("lu3", s);
            if (!s) break;
            n++;
        end
`ifdef ID_EX_FORWARD_EN
        exp_n = 1; exp_v = 32'h33;
`else
        exp_n = 3; exp_v = 32'h99;
`endif
        chk("lu3.stall_cycles", 152'(n), 152'(exp_n));
        chk("lu3.op1", {120'b0, ex_op1}, {120'b0, exp_v});
        drain();

        // Flush arriving together with a pending load-use
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'd0, 32'd0);
        cycle("lw3b", s);
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0, 32'h1, 32'h2);
        flush = 1'b1;
        cycle("flush", s);
        chk("flush.stall_id", {151'b0, s}, 152'd0);
        chk("flush.ex_valid", {151'b0, ex_valid}, 152'd0);
        chk("flush.ex_reg_wr", {151'b0, ex_reg_wr}, 152'd0);
        flush = 1'b0;
        drain();

        // Reset in the middle of a load-use stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'd0, 32'd0);
        cycle("lw3c", s);
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 32'h7, 32'd0);
        reset = 1'b1;
        cycle("rst_mid", s);
        chk("rst_mid.stall_id", {151'b0, s}, 152'd0);
        chk("rst_mid.ex_valid", {151'b0, ex_valid}, 152'd0);
        reset = 1'b0;
        drain();

        // x0 source must ignore a MEM producer that claims rd=0
        pipe_mode = 1'b0;
        mem_rd = 5'd0; mem_reg_wr = 1'b1; mem_result = 32'hBAD;
        wb_rd = 5'd0;  wb_reg_wr = 1'b0;
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle("x0", s);
        chk("x0.op2", {120'b0, ex_op2}, 152'd0);

`ifdef ID_EX_FORWARD_EN
        // EX producer beats MEM producer of the same register
        mem_reg_wr = 1'b0;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle("prio_ex", s);
        ex_alu_result = 32'hA; mem_rd = 5'd7; mem_reg_wr = 1'b1; mem_result = 32'hB;
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 32'd0, 32'h5);
        cycle("prio", s);
        chk("prio.op2", {120'b0, ex_op2}, {120'b0, 32'hA});
`endif

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 39) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            ex_alu_result = $urandom;
            mem_rd        = 5'($urandom_range(0, 3));
            mem_reg_wr    = 1'($urandom);
            mem_result    = $urandom;
            wb_rd         = 5'($urandom_range(0, 3));
            wb_reg_wr     = 1'($urandom);
            wb_wdata      = $urandom;
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), $urandom_range(0, 2) == 0, $urandom, $urandom);
            cycle("rand", s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: id_valid  in  1  decode slot holds a real instruction.
REQ-004 SHALL have: id_pc  in  32  decode PC; id_imm  in  32  decoded immediate; id_ctrl  in  16  opaque ALU/branch/mem control.
REQ-005 SHALL have: id_rs1, id_rs2, id_rd  in  5 each  source/dest register indices.
REQ-006 SHALL have: id_use_rs1, id_use_rs2  in  1 each  operand actually read.
REQ-007 SHALL have: id_rdata1, id_rdata2  in  32 each  register-file read data.
REQ-008 SHALL have: id_reg_wr, id_mem_rd  in  1 each  writes rd / is a load.
REQ-009 SHALL have: ex_alu_result  in  32  ALU output of instruction currently held here.
REQ-010 SHALL have: mem_rd, mem_reg_wr, mem_result  in  5/1/32  MEM-stage dest, write-enable, result.
REQ-011 SHALL have: wb_rd, wb_reg_wr, wb_wdata  in  5/1/32  WB-stage dest, write-enable, data.
REQ-012 SHALL have: flush  in  1  kill decode slot (taken branch/jump).
REQ-013 SHALL have registered outputs ex_valid 1, ex_pc 32, ex_op1 32, ex_op2 32, ex_imm 32, ex_ctrl 16, ex_rd 5, ex_reg_wr 1, ex_mem_rd 1.
REQ-014 SHALL have: stall_id  out  1  combinational; upstream holds PC/IF-ID when high.

Function
REQ-015 SHALL capture all id_* fields into ex_* on each posedge when not stalled and not flushed; latency one cycle.
REQ-016 SHALL compute ex_op1/ex_op2 at capture with bypass priority: held EX instruction (ex_valid & ex_reg_wr & ex_rd match) > MEM (mem_reg_wr & mem_rd match) > WB (wb_reg_wr & wb_rd match) > id_rdataN.
REQ-017 SHALL never bypass for source index 0; operand from x0 is always id_rdataN (zero).
REQ-018 SHALL assert stall_id when ex_valid & ex_mem_rd & ex_rd!=0 and ex_rd equals a used id source (load-use).
REQ-019 SHALL, on stall, load a bubble: ex_valid, ex_reg_wr, ex_mem_rd = 0; other ex_* fields don't-care but held stable.
REQ-020 SHALL, on flush, load a bubble identically; flush overrides stall; stall_id SHALL be 0 when flush=1.
REQ-021 SHALL treat id_valid=0 as a bubble; stall_id SHALL be 0 when id_valid=0.
REQ-022 SHALL gate ex_reg_wr and ex_mem_rd with ex_valid (never 1 while ex_valid=0).
REQ-023 SHALL release stall after exactly one bubble for a single load-use dependency (load then in MEM, served by MEM bypass).

Reset
REQ-024 SHALL clear every ex_* output to 0 on posedge with reset=1, regardless of flush/stall.
REQ-025 SHALL hold stall_id=0 while reset=1; reset mid-stall discards the stalled instruction.

Configuration
REQ-026 SHALL compile bypass network in only when macro ID_EX_FORWARD_EN is defined.
REQ-027 With ID_EX_FORWARD_EN: behaviour per REQ-016..REQ-023.
REQ-028 Without ID_EX_FORWARD_EN: operands always id_rdataN; stall_id asserted while any of EX(held, valid), MEM or WB has reg_wr, nonzero rd matching a used source; bubbles per REQ-019; ex_alu_result/mem_result/wb_wdata unused.

Verification
REQ-029 Reset: reset=1 two cycles with id_valid=1 -> all ex_*=0, stall_id=0.
REQ-030 EX bypass: held add x5 (ex_alu_result=0x11), next id rs1=5, id_rdata1=0x0 -> ex_op1=0x11 next cycle.
REQ-031 Priority: EX rd=7 result 0xA, MEM rd=7 result 0xB, id rs2=7 -> ex_op2=0xA; x0 source with MEM rd=0 -> ex_op2=id_rdata2.
REQ-032 Load-use: held lw x3, id rs1=3 used -> stall_id=1 one cycle, bubble ex_valid=0, then ex_op1=mem_result.
REQ-033 Flush+stall same cycle: flush=1 with load-use pending -> stall_id=0, ex_valid=0 next cycle.
REQ-034 No-forward build: add x4 then use x4 -> stall_id=1 for 3 cycles (EX, MEM, WB), then ex_op1=id_rdata1.
